// File: rtl/inner_mem_arbiter.sv
// rtl/inner_mem_arbiter.sv - data/ifetch arbiter and fixed-latency sequencer for the single-port inner memory
module inner_mem_arbiter #(
    parameter int   MEM_LATENCY  = 1,
    parameter int   STARVE_LIMIT = 4,
    parameter logic IFETCH_TYPE  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_type,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    output logic        mem_rw,
    output logic        mem_type,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam int LW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LATENCY);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] lat_cnt, lat_cnt_nxt;
    logic [SW-1:0] starve_cnt, starve_cnt_nxt;
    logic          grant_i, grant_d, capture;

    // cmd_owner: 1 = instruction fetch, 0 = data port
    logic          cmd_owner;
    logic          cmd_rw;
    logic          cmd_type;
    logic [31:0]   cmd_addr;
    logic [31:0]   cmd_wdata;

    always_comb begin
        state_nxt      = state;
        lat_cnt_nxt    = lat_cnt;
        starve_cnt_nxt = starve_cnt;
        grant_i        = 1'b0;
        grant_d        = 1'b0;
        capture        = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && (!d_req || starve_cnt == STARVE_MAX)) begin
                    grant_i        = 1'b1;
                    starve_cnt_nxt = '0;
                    state_nxt      = ACC;
                    lat_cnt_nxt    = LAT_INIT;
                end else if (d_req) begin
                    grant_d = 1'b1;
                    if (i_req && starve_cnt != STARVE_MAX) begin
                        starve_cnt_nxt = starve_cnt + SW'(1);
                    end
                    state_nxt   = ACC;
                    lat_cnt_nxt = LAT_INIT;
                end
            end
            ACC: begin
                if (lat_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    lat_cnt_nxt = lat_cnt - LW'(1);
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            cmd_owner  <= 1'b0;
            cmd_rw     <= 1'b0;
            cmd_type   <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            d_rdata    <= '0;
            i_rdata    <= '0;
        end else begin
            state      <= state_nxt;
            lat_cnt    <= lat_cnt_nxt;
            starve_cnt <= starve_cnt_nxt;
            // fetches leave cmd_wdata untouched so the write-data bus does not toggle
            if (grant_i) begin
                cmd_owner <= 1'b1;
                cmd_rw    <= 1'b0;
                cmd_type  <= IFETCH_TYPE;
                cmd_addr  <= i_addr;
            end else if (grant_d) begin
                cmd_owner <= 1'b0;
                cmd_rw    <= d_we;
                cmd_type  <= d_type;
                cmd_addr  <= d_addr;
                cmd_wdata <= d_wdata;
            end
            if (capture) begin
                if (cmd_owner) begin
                    i_rdata <= mem_rdata;
                end else begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

    // lat_cnt still equals its load value only in the first ACC cycle, so a write fires once
    assign mem_rw    = (state == ACC) && (lat_cnt == LAT_INIT) && cmd_rw;
    assign mem_type  = cmd_type;
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;
    assign d_ready   = (state == RESP) && !cmd_owner;
    assign i_ready   = (state == RESP) && cmd_owner;
    assign busy      = (state != IDLE);

endmodule
